alu_rs: RTL

- Reservation station feeding the ALU functional unit. It buffers renamed ALU micro-ops from dispatch and snoops the CDB to capture pending source values.
- It issues the oldest fully-ready entry to the ALU FU input port: transmit pulse plus operand, depvals, wbs, flags and robid.
- It sits between the rename/dispatch stage and the ALU FU, and respects the FU busy stall.

---
 rtl/alu_rs.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs -- reservation station in front of the ALU functional unit.
//
// Buffers renamed ALU micro-ops from dispatch in a compacted age queue
// (entry 0 is the oldest, valid entries are contiguous from index 0), snoops
// the CDB to capture pending source values, and issues the oldest entry whose
// two sources are ready to the ALU FU as a one-cycle transmit strobe.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset (0 = reset)
//   in_valid/in_ready   dispatch handshake; in_ready = occupancy < DEPTH
//   in_operand/wbs/     micro-op payload; in_flags[2] marks the immediate
//   flags/robid         form (source 1 forced ready with value 0)
//   in_src_rdy/val/tag  per-source ready bit, value (if ready), producer tag
//                       (if not ready); source s lives in bits [8s+:8]/[4s+:4]
//   cdb_valid/id/val    result broadcast used for wakeup and allocation bypass
//   flush               synchronous squash of every entry
//   fu_busy             FU stall; no issue while high
//   fu_transmit         one-cycle issue strobe
//   fu_operand/depvals/ issued fields; fu_depvals[7:0] = source 0,
//   wbs/flags/robid     fu_depvals[15:8] = source 1; held while not issuing
//   occupancy           number of valid entries
// -----------------------------------------------------------------------------
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_operand,
  input  logic [7:0]    in_wbs,
  input  logic [7:0]    in_flags,
  input  logic [3:0]    in_robid,
  input  logic [1:0]    in_src_rdy,
  input  logic [15:0]   in_src_val,
  input  logic [7:0]    in_src_tag,
  input  logic          cdb_valid,
  input  logic [3:0]    cdb_id,
  input  logic [7:0]    cdb_val,
  input  logic          flush,
  input  logic          fu_busy,
  output logic          fu_transmit,
  output logic [7:0]    fu_operand,
  output logic [15:0]   fu_depvals,
  output logic [7:0]    fu_wbs,
  output logic [7:0]    fu_flags,
  output logic [3:0]    fu_robid,
  output logic [CW-1:0] occupancy
);

  // Packed entry layout. Each entry moves as one vector so that shifting
  // down the queue carries every field, including per-source state, at once.
  localparam int OP_LSB  = 0;
  localparam int WBS_LSB = 8;
  localparam int FLG_LSB = 16;
  localparam int ROB_LSB = 24;
  localparam int RDY_LSB = 28;   // 2 bits, one per source
  localparam int VAL_LSB = 30;   // 2 x 8 bits
  localparam int TAG_LSB = 46;   // 2 x 4 bits
  localparam int EW      = 54;

  // Returns the entry as it will look after this cycle's CDB snoop: any
  // not-ready source whose tag matches the broadcast captures its value.
  function automatic logic [EW-1:0] wake(
    input logic [EW-1:0] e,
    input logic          v,
    input logic [3:0]    id,
    input logic [7:0]    val
  );
    logic [EW-1:0] r;
    r = e;
    for (int s = 0; s < 2; s++) begin
      if (v && !e[RDY_LSB + s] && (e[TAG_LSB + 4*s +: 4] == id)) begin
        r[RDY_LSB + s]        = 1'b1;
        r[VAL_LSB + 8*s +: 8] = val;
      end
    end
    return r;
  endfunction

  // State
  logic [EW-1:0] ent_q [DEPTH];
  logic [EW-1:0] ent_d [DEPTH];
  logic [CW-1:0] occ_q;
  logic [CW-1:0] occ_d;
  logic          fu_transmit_q;
  logic          fu_transmit_d;
  logic [7:0]    fu_operand_q;
  logic [15:0]   fu_depvals_q;
  logic [7:0]    fu_wbs_q;
  logic [7:0]    fu_flags_q;
  logic [3:0]    fu_robid_q;

  // Combinational
  logic [EW-1:0]    ent_w [DEPTH+1];   // post-wakeup view; extra slot is the
                                       // empty "entry" shifted into the top
  logic [DEPTH-1:0] valid_w;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] shift_en;
  logic             any_elig;
  logic             issue;
  logic             alloc;
  logic             found;
  logic [CW-1:0]    alloc_pos;
  logic [EW-1:0]    new_ent;
  logic [1:0]       new_rdy;
  logic [15:0]      new_val;
  logic [7:0]       sel_op;
  logic [7:0]       sel_wbs;
  logic [7:0]       sel_flg;
  logic [3:0]       sel_rob;
  logic [15:0]      sel_val;

  assign in_ready = (occ_q < CW'(DEPTH));
  assign alloc    = in_valid & in_ready;

  // Per-entry validity, eligibility (registered ready bits only, so a source
  // woken this cycle cannot issue before the next one) and wakeup view.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      localparam logic [CW-1:0] IDX = CW'(gi);
      assign valid_w[gi] = (IDX < occ_q);
      assign elig[gi]    = valid_w[gi] & ent_q[gi][RDY_LSB] & ent_q[gi][RDY_LSB+1];
      assign ent_w[gi]   = wake(ent_q[gi], cdb_valid, cdb_id, cdb_val);
    end
  endgenerate
  assign ent_w[DEPTH] = '0;

  // Incoming micro-op: allocation bypass from the CDB, then immediate form
  // overrides source 1.
  always_comb begin
    new_rdy = in_src_rdy;
    new_val = in_src_val;
    for (int s = 0; s < 2; s++) begin
      if (!in_src_rdy[s] && cdb_valid && (in_src_tag[4*s +: 4] == cdb_id)) begin
        new_rdy[s]        = 1'b1;
        new_val[8*s +: 8] = cdb_val;
      end
    end
    if (in_flags[2]) begin
      new_rdy[1]    = 1'b1;
      new_val[15:8] = 8'h00;
    end
    new_ent = {in_src_tag, new_val, new_rdy, in_robid, in_flags, in_wbs, in_operand};
  end

  // Oldest-first select. 'found' becomes a prefix-OR of eligibility, which
  // is exactly the set of entries at or above the issued one -- those shift
  // down by one when an issue happens.
  always_comb begin
    any_elig = |elig;
    // Back-to-back issue is blocked by our own strobe: at most one issue
    // every two cycles.
    issue    = ~fu_busy & ~fu_transmit_q & any_elig;
    found    = 1'b0;
    shift_en = '0;
    sel_op   = '0;
    sel_wbs  = '0;
    sel_flg  = '0;
    sel_rob  = '0;
    sel_val  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !found) begin
        sel_op  = ent_q[i][OP_LSB  +: 8];
        sel_wbs = ent_q[i][WBS_LSB +: 8];
        sel_flg = ent_q[i][FLG_LSB +: 8];
        sel_rob = ent_q[i][ROB_LSB +: 4];
        sel_val = ent_q[i][VAL_LSB +: 16];
      end
      found       = found | elig[i];
      shift_en[i] = issue & found;
    end
  end

  // Entry next state: shift (with wakeup already applied to the shifted
  // copy), then overlay the new allocation at the first free slot after the
  // shift.
  always_comb begin
    alloc_pos = occ_q - CW'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = shift_en[i] ? ent_w[i+1] : ent_w[i];
      if (alloc && (alloc_pos == CW'(i))) begin
        ent_d[i] = new_ent;
      end
    end
  end

  // Flush wins over both allocation and issue.
  always_comb begin
    if (flush) begin
      occ_d         = '0;
      fu_transmit_d = 1'b0;
    end else begin
      occ_d         = occ_q + CW'(alloc) - CW'(issue);
      fu_transmit_d = issue;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q         <= '0;
      fu_transmit_q <= 1'b0;
      fu_operand_q  <= '0;
      fu_depvals_q  <= '0;
      fu_wbs_q      <= '0;
      fu_flags_q    <= '0;
      fu_robid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      occ_q         <= occ_d;
      fu_transmit_q <= fu_transmit_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      // Data outputs only change on an actual issue and hold otherwise.
      if (fu_transmit_d) begin
        fu_operand_q <= sel_op;
        fu_depvals_q <= sel_val;
        fu_wbs_q     <= sel_wbs;
        fu_flags_q   <= sel_flg;
        fu_robid_q   <= sel_rob;
      end
    end
  end

  assign fu_transmit = fu_transmit_q;
  assign fu_operand  = fu_operand_q;
  assign fu_depvals  = fu_depvals_q;
  assign fu_wbs      = fu_wbs_q;
  assign fu_flags    = fu_flags_q;
  assign fu_robid    = fu_robid_q;
  assign occupancy   = occ_q;

endmodule
